// File: rtl/led_seq_ctrl_if.sv
// Pin-side bundle for the LED sequencer: raw slide switches in, LED bank and
// prescaler tick out. The board/bench drives the master side.
interface led_seq_ctrl_if;
  logic [3:0]  sw;
  logic [11:0] led;
  logic        tick;

  modport master (output sw, input led, tick);
  modport slave  (input sw, output led, tick);
endinterface

// File: rtl/led_seq_ctrl.sv
// 12-LED pattern sequencer: debounced switches pick mode/run/direction and the
// pattern advances once per prescaler wrap.
module led_seq_ctrl #(
  parameter int unsigned TICK_DIV  = 8388608,
  parameter int unsigned DB_CYCLES = 65536
) (
  input  logic          clk,
  input  logic          rst,
  led_seq_ctrl_if.slave bus
);

  localparam int unsigned PS_W = $clog2(TICK_DIV);
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0] PS_PRE  = PS_W'(TICK_DIV - 2);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;

  logic [PS_W-1:0] ps_cnt;
  logic            tick_q;
  logic [3:0]      sync1, sync2, sw_db;
  logic [DB_W-1:0] db_cnt [4];
  logic [2:0]      state, mode_st;
  logic [11:0]     pattern, step_val, seed_val, led_q;

  // tick is registered one count early so it is high while ps_cnt == TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt <= '0;
      tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
      tick_q <= (ps_cnt == PS_PRE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.sw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_db <= '0;
      // NOTE: the counter array is a handful of flops, not RAM, so it is cleared with everything else.
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == sw_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          sw_db[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    mode_st  = ST_OFF;
    step_val = pattern;
    unique case (sw_db[3:2])
      2'b00: mode_st = ST_OFF;
      2'b01: mode_st = ST_COUNT;
      2'b10: mode_st = ST_SCAN;
      2'b11: mode_st = ST_FILL;
      default: mode_st = ST_OFF;
    endcase
    case (state)
      ST_COUNT: step_val = sw_db[1] ? pattern - 12'd1 : pattern + 12'd1;
      ST_SCAN:  step_val = sw_db[1] ? {pattern[0], pattern[11:1]}
                                    : {pattern[10:0], pattern[11]};
      ST_FILL: begin
        if (sw_db[1]) step_val = (pattern == 12'h000) ? 12'hFFF : pattern >> 1;
        else          step_val = (pattern == 12'hFFF) ? 12'h000 : {pattern[10:0], 1'b1};
      end
      default: step_val = pattern;
    endcase
    seed_val = (mode_st == ST_SCAN) ? 12'h001 : 12'h000;
  end

  // LOAD re-reads the decoded mode, so a change that lands during LOAD is
  // picked up by the next mode comparison rather than lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_OFF;
      pattern <= '0;
      led_q   <= '0;
    end else begin
      led_q <= pattern;
      if (state == ST_LOAD) begin
        state   <= mode_st;
        pattern <= seed_val;
      end else begin
        if (mode_st != state) state <= ST_LOAD;
        if (state == ST_OFF)              pattern <= '0;
        else if (tick_q && sw_db[0])      pattern <= step_val;
      end
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencer for the 12-LED board bank.
- Debounces the 4 slide switches and uses them to select one of four LED pattern modes, plus run/pause and direction.
- Advances the selected pattern on a prescaled tick.
- Sits between the top-level switch/LED pins and replaces ad-hoc counter-driven LED logic in board examples.

Parameters:
- TICK_DIV, 8388608, clk cycles per pattern step (must be >= 2).
- DB_CYCLES, 65536, consecutive stable cycles required before a switch change is accepted (must be >= 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sw  input  4  raw switches, asynchronous to clk:
  - sw[0] = run.
  - sw[1] = direction.
  - sw[3:2] = mode.
- led  output  12  registered LED pattern.
- tick  output  1  one-cycle pulse per prescaler wrap (debug/observability).

Behaviour:
- Reset (async, active-high): all flops clear.
  - led = 0, tick = 0, prescaler = 0.
  - Synchronisers, debounced switches and debounce counters = 0.
  - pattern = 0, state = OFF.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for exactly the cycle in which the counter equals TICK_DIV-1 (registered).
  - Free-running; unaffected by mode or run.
- Synchroniser: 2-FF per switch bit.
- Debounce, per bit:
  - If the sync output equals sw_db, the counter is cleared.
  - Otherwise the counter increments; when it reaches DB_CYCLES-1, sw_db takes the sync value and the counter clears.
  - A raw change held for DB_CYCLES+2 or more cycles is accepted. Glitches shorter than DB_CYCLES cycles are never accepted.
- Mode decode from sw_db[3:2]: 00 = OFF, 01 = COUNT, 10 = SCAN, 11 = FILL.
- FSM states: OFF, COUNT, SCAN, FILL, LOAD.
  - Any state, decoded mode != current mode state → LOAD on the next clock. From LOAD, a mode change is simply re-evaluated.
  - LOAD lasts exactly 1 cycle. It seeds the pattern for the target mode, then enters that mode.
  - Seeds: OFF 0x000, COUNT 0x000, SCAN 0x001, FILL 0x000.
  - LOAD has priority over a coincident tick; that tick is dropped.
- Step rule: the pattern advances only when tick=1, sw_db[0]=1, and state is COUNT, SCAN or FILL. Otherwise the pattern holds (pause).
- Step operations by mode (dir = sw_db[1]):
  - COUNT, dir 0: pattern+1 modulo 4096 (0xFFF → 0x000).
  - COUNT, dir 1: pattern-1 (0x000 → 0xFFF).
  - SCAN, dir 0: rotate left (0x800 → 0x001).
  - SCAN, dir 1: rotate right (0x001 → 0x800).
  - A direction change continues from the current pattern, with no reseed.
  - FILL, dir 0: {pattern[10:0],1}; 0xFFF → 0x000.
  - FILL, dir 1: pattern>>1; 0x000 → 0xFFF.
  - OFF: pattern forced to 0.
- Output timing: led is registered from pattern, so led reflects pattern 1 cycle after it updates.
- Reset mid-operation: immediate async clear. After release, the FSM sits in OFF until debounced switches select a mode.

Test Plan:
All tests use TICK_DIV=4, DB_CYCLES=3.
- Reset/glitch: assert rst with sw=4'b0101, release; pulse sw[2] low for 2 cycles → led stays 0x000 until the mode is accepted. A 2-cycle glitch after acceptance produces no LOAD.
- COUNT up: sw=4'b0101 held → after ≤5 cycles LOAD, then led steps 0x001, 0x002, 0x003 at 4-cycle spacing. Preload via 4095 steps or force: 0xFFF → 0x000.
- SCAN bounce: sw=4'b1001 → led 0x001, 0x002 … 0x800, 0x001. Set sw[1]=1 while at 0x004 → next steps 0x002, 0x001, 0x800.
- FILL: sw=4'b1101 → 0x001, 0x003, 0x007 … 0xFFF, 0x000. With dir=1 from 0x007 → 0x003, 0x001, 0x000, 0xFFF.
- Pause/reseed: in COUNT at 0x005, set sw[0]=0 → led holds 0x005 across ≥3 ticks. Switch to SCAN with a tick coincident with LOAD → led=0x001 and no extra step that cycle.
- Async reset mid-run: assert rst asynchronously during SCAN at 0x040 → led=0x000 and tick=0 within the same cycle; after release, the mode is reacquired and SCAN restarts at 0x001.
